vram_writer: RTL and testbench

- CPU-side write/read port for the Vector-06C four-plane video RAM; the opposite end of the display fetch path.
- Accepts CPU byte writes and reads in the video window.
- Queues writes in a small FIFO and drains them into the shared 32-bit VRAM port whenever the display fetcher is not using it.
- Display fetches always win arbitration. CPU reads are ordered behind all pending writes.

---
 rtl/vram_writer.sv | 255 +++++++++++++++++++++++++
 tb/tb_vram_writer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_writer.sv
// vram_writer: CPU-side access port for the four-plane video RAM.
// CPU byte writes are queued in a small FIFO and drained into the shared
// 32-bit VRAM port in cycles the display fetcher leaves idle. Display fetches
// always win the port. CPU reads wait behind every queued write.
//
// Ports:
//   clk_sys, reset_n          clock, asynchronous active-low reset
//   cpu_addr/cpu_win          address (plane [14:13], offset [12:0]), window hit
//   cpu_dout/cpu_wr/cpu_rd    write data and level strobes (rising edge acts)
//   cpu_din/cpu_ready         read data, low while the CPU must wait
//   vid_req/vid_addr          display fetch request and word address
//   vid_data/vid_valid        fetched word {p0,p1,p2,p3}, one-cycle update pulse
//   ram_addr/we/be/wdata      shared VRAM port (driven in the granted cycle)
//   ram_rdata                 VRAM read data, valid the cycle after the address
//   overflow                  sticky: a write was lost
//   fifo_empty                no queued or held writes
module vram_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 13
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [15:0]       cpu_addr,
  input  logic              cpu_win,
  input  logic [7:0]        cpu_dout,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  output logic [7:0]        cpu_din,
  output logic              cpu_ready,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [31:0]       vid_data,
  output logic              vid_valid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              overflow,
  output logic              fifo_empty
);

  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] offset;
    logic [1:0]        lane;
    logic [7:0]        data;
  } wr_entry_t;

  typedef enum logic [1:0] {IDLE, DRAIN, ISSUE, WAIT} rd_state_t;

  logic              old_wr_reg, old_rd_reg;
  logic              wr_event, rd_event;
  logic [1:0]        cpu_lane;
  wr_entry_t         new_entry;
  wr_entry_t         fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
  logic              fifo_none, fifo_full;
  logic              hold_valid_reg, hold_valid_next;
  wr_entry_t         hold_entry_reg;
  logic              push, hold_load, hold_push, lose;
  wr_entry_t         push_entry, pop_entry;
  logic              vid_grant, pop, rd_issue;
  logic              vid_fetch_reg, vid_valid_reg;
  logic [31:0]       vid_data_reg;
  logic              wr_ready_reg, overflow_reg, fifo_empty_reg;
  rd_state_t         rd_state_reg, rd_state_next;
  logic              rd_ready_reg, rd_ready_next;
  logic [7:0]        cpu_din_reg, cpu_din_next;
  logic [ADDR_W-1:0] rd_offset_reg, rd_offset_next;
  logic [1:0]        rd_lane_reg, rd_lane_next;
  logic [7:0]        rdata_lane [4];
  logic              unused_addr_bit;

  assign unused_addr_bit = cpu_addr[15];

  assign wr_event  = cpu_wr & ~old_wr_reg & cpu_win;
  assign rd_event  = cpu_rd & ~old_rd_reg & cpu_win;
  // Plane 0 lives in the top byte, plane 3 in the bottom byte.
  assign cpu_lane  = 2'd3 - cpu_addr[14:13];
  assign new_entry = {cpu_addr[ADDR_W-1:0], cpu_lane, cpu_dout};

  // Pointers carry one extra wrap bit: equal means empty, MSB-only difference means full.
  assign fifo_none = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full = (wr_ptr_reg[IDX_W] != rd_ptr_reg[IDX_W]) &&
                     (wr_ptr_reg[IDX_W-1:0] == rd_ptr_reg[IDX_W-1:0]);
  assign pop_entry = fifo_mem[rd_ptr_reg[IDX_W-1:0]];

  // Capture side: the hold register is an overflow slot of depth one. While it is
  // occupied it owns the push path, and any further write event is discarded.
  always_comb begin
    push       = 1'b0;
    push_entry = new_entry;
    hold_load  = 1'b0;
    hold_push  = 1'b0;
    lose       = 1'b0;
    if (hold_valid_reg) begin
      if (!fifo_full) begin
        push       = 1'b1;
        push_entry = hold_entry_reg;
        hold_push  = 1'b1;
      end
      if (wr_event) begin
        lose = 1'b1;
      end
    end else if (wr_event) begin
      if (!fifo_full) begin
        push = 1'b1;
      end else begin
        hold_load = 1'b1;
      end
    end
  end

  // Port arbitration: display fetch, then queued write, then the CPU read.
  // The fetch grant is gated by reset so the port reads all-zero while held in reset.
  assign vid_grant = reset_n & vid_req;
  assign pop       = ~vid_req & ~fifo_none;
  assign rd_issue  = ~vid_req & fifo_none & (rd_state_reg == ISSUE);

  always_comb begin
    ram_addr = '0;
    if (vid_grant) begin
      ram_addr = vid_addr;
    end else if (pop) begin
      ram_addr = pop_entry.offset;
    end else if (rd_issue) begin
      ram_addr = rd_offset_reg;
    end
  end

  assign ram_we = pop;
  assign ram_be = pop ? (4'b0001 << pop_entry.lane) : 4'b0000;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rdata_lane[gi]       = ram_rdata[gi*8 +: 8];
      assign ram_wdata[gi*8 +: 8] = pop ? pop_entry.data : 8'h00;
    end
  endgenerate

  always_comb begin
    wr_ptr_next     = wr_ptr_reg + PTR_W'(push);
    rd_ptr_next     = rd_ptr_reg + PTR_W'(pop);
    hold_valid_next = hold_valid_reg;
    if (hold_load) begin
      hold_valid_next = 1'b1;
    end else if (hold_push) begin
      hold_valid_next = 1'b0;
    end
  end

  // CPU read sequencer.
  always_comb begin
    rd_state_next  = rd_state_reg;
    rd_ready_next  = rd_ready_reg;
    cpu_din_next   = cpu_din_reg;
    rd_offset_next = rd_offset_reg;
    rd_lane_next   = rd_lane_reg;
    case (rd_state_reg)
      IDLE: begin
        if (rd_event) begin
          rd_state_next  = DRAIN;
          rd_ready_next  = 1'b0;
          rd_offset_next = cpu_addr[ADDR_W-1:0];
          rd_lane_next   = cpu_lane;
        end
      end
      DRAIN: begin
        // An empty FIFO means its last entry was already presented to the port.
        if (fifo_none && !hold_valid_reg) begin
          rd_state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (rd_issue) begin
          rd_state_next = WAIT;
        end
      end
      WAIT: begin
        cpu_din_next  = rdata_lane[rd_lane_reg];
        rd_ready_next = 1'b1;
        rd_state_next = IDLE;
      end
      default: rd_state_next = IDLE;
    endcase
  end

  // Queue storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_mem[wr_ptr_reg[IDX_W-1:0]] <= push_entry;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      old_wr_reg     <= 1'b0;
      old_rd_reg     <= 1'b0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      hold_valid_reg <= 1'b0;
      hold_entry_reg <= '0;
      wr_ready_reg   <= 1'b1;
      overflow_reg   <= 1'b0;
      fifo_empty_reg <= 1'b1;
      vid_fetch_reg  <= 1'b0;
      vid_valid_reg  <= 1'b0;
      vid_data_reg   <= '0;
      rd_state_reg   <= IDLE;
      rd_ready_reg   <= 1'b1;
      cpu_din_reg    <= '0;
      rd_offset_reg  <= '0;
      rd_lane_reg    <= '0;
    end else begin
      old_wr_reg     <= cpu_wr;
      old_rd_reg     <= cpu_rd;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      hold_valid_reg <= hold_valid_next;
      if (hold_load) begin
        hold_entry_reg <= new_entry;
        wr_ready_reg   <= 1'b0;
      end else if (hold_push) begin
        wr_ready_reg   <= 1'b1;
      end
      if (lose) begin
        overflow_reg <= 1'b1;
      end
      fifo_empty_reg <= (wr_ptr_next == rd_ptr_next) && !hold_valid_next;
      // The fetch address is sampled by the RAM at this edge; its data arrives next cycle.
      vid_fetch_reg  <= vid_grant;
      vid_valid_reg  <= vid_fetch_reg;
      if (vid_fetch_reg) begin
        vid_data_reg <= ram_rdata;
      end
      rd_state_reg   <= rd_state_next;
      rd_ready_reg   <= rd_ready_next;
      cpu_din_reg    <= cpu_din_next;
      rd_offset_reg  <= rd_offset_next;
      rd_lane_reg    <= rd_lane_next;
    end
  end

  assign cpu_ready  = rd_ready_reg & wr_ready_reg;
  assign cpu_din    = cpu_din_reg;
  assign vid_data   = vid_data_reg;
  assign vid_valid  = vid_valid_reg;
  assign overflow   = overflow_reg;
  assign fifo_empty = fifo_empty_reg;

endmodule

// File: tb/tb_vram_writer.sv
// Testbench for vram_writer: a behavioural VRAM with one-cycle read latency,
// a table of single-write / read-back vectors, and hand-written sequences for
// display priority, overflow, read-after-write and asynchronous reset.
module tb_vram_writer;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] cpu_addr = '0;
  logic        cpu_win = 1'b0;
  logic [7:0]  cpu_dout = '0;
  logic        cpu_wr = 1'b0;
  logic        cpu_rd = 1'b0;
  logic [7:0]  cpu_din;
  logic        cpu_ready;
  logic        vid_req = 1'b0;
  logic [12:0] vid_addr = '0;
  logic [31:0] vid_data;
  logic        vid_valid;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic        overflow;
  logic        fifo_empty;

  vram_writer #(.FIFO_DEPTH(4), .ADDR_W(13)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_win(cpu_win), .cpu_dout(cpu_dout),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_din(cpu_din), .cpu_ready(cpu_ready),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_be(ram_be), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .overflow(overflow), .fifo_empty(fifo_empty)
  );

  always #5 clk_sys = ~clk_sys;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int viol_cnt = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Behavioural VRAM: byte-masked writes, registered read.
  logic [31:0] vram [8192];
  always @(posedge clk_sys) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) vram[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end
    end
    ram_rdata <= vram[ram_addr];
  end

  typedef struct {
    logic [12:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          cyc;
  } wr_rec_t;
  wr_rec_t     wr_q[$];
  logic [31:0] vid_q[$];

  always @(negedge clk_sys) begin
    if (ram_we) wr_q.push_back('{ram_addr, ram_be, ram_wdata, cyc});
    if (ram_we && vid_req) viol_cnt++;
    if (vid_valid) vid_q.push_back(vid_data);
  end

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic [12:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [7:0]  exp_din;
  } vec_t;
  vec_t vec [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk_sys); #1;
    end
  endtask

  // One write strobe: high for one cycle, then low for one cycle.
  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_dout = d; cpu_win = 1'b1; cpu_wr = 1'b1;
    @(posedge clk_sys); #1;
    cpu_wr = 1'b0; cpu_win = 1'b0;
    @(posedge clk_sys); #1;
  endtask

  // Read strobe, then count cycles with cpu_ready low (bounded).
  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d, output int lat);
    cpu_addr = a; cpu_win = 1'b1; cpu_rd = 1'b1;
    @(posedge clk_sys); #1;
    cpu_rd = 1'b0; cpu_win = 1'b0;
    lat = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_sys);
      if (cpu_ready) break;
      lat++;
      @(posedge clk_sys); #1;
    end
    d = cpu_din;
    @(posedge clk_sys); #1;
  endtask

  // Wait (bounded) until n writes have been seen on the RAM port.
  task automatic wait_writes(input int n);
    for (int i = 0; i < 20; i++) begin
      if (wr_q.size() >= n) break;
      @(posedge clk_sys); #1;
    end
    check("wr_count", 32'(wr_q.size()), 32'(n));
  endtask

  initial begin
    logic [7:0] d;
    int lat, n0, c0, v_end, low_cnt;

    for (int i = 0; i < 8192; i++) vram[i] = 32'h0;
    for (int k = 0; k < 10; k++) vram[13'h1000 + k] = 32'hC0DE_0000 + 32'(k);

    vec[0] = '{16'hA105, 8'h5A, 13'h0105, 4'b0100, 32'h5A5A5A5A, 8'h5A};
    vec[1] = '{16'hE0FF, 8'hE1, 13'h00FF, 4'b0001, 32'hE1E1E1E1, 8'hE1};
    vec[2] = '{16'h8010, 8'hC3, 13'h0010, 4'b1000, 32'hC3C3C3C3, 8'hC3};
    vec[3] = '{16'hC1FF, 8'h77, 13'h01FF, 4'b0010, 32'h77777777, 8'h77};
    vec[4] = '{16'h9FFF, 8'hA5, 13'h1FFF, 4'b1000, 32'hA5A5A5A5, 8'hA5};
    vec[5] = '{16'h4105, 8'h96, 13'h0105, 4'b0010, 32'h96969696, 8'h96};

    // Reset values
    #1 reset_n = 1'b0;
    #2;
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_be", 32'(ram_be), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    check("rst_cpu_ready", 32'(cpu_ready), 32'd1);
    check("rst_cpu_din", 32'(cpu_din), 32'd0);
    check("rst_vid_data", vid_data, 32'd0);
    check("rst_vid_valid", 32'(vid_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_fifo_empty", 32'(fifo_empty), 32'd1);
    $display("reset: outputs checked");
    cycles(3);
    reset_n = 1'b1;
    cycles(2);

    // Window gating: strobes outside the video window do nothing
    n0 = wr_q.size();
    low_cnt = 0;
    cpu_addr = 16'hA105; cpu_dout = 8'hFF; cpu_win = 1'b0; cpu_wr = 1'b1;
    cycles(1);
    cpu_wr = 1'b0;
    cycles(1);
    cpu_rd = 1'b1;
    cycles(1);
    cpu_rd = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_sys);
      if (!cpu_ready) low_cnt++;
      @(posedge clk_sys); #1;
    end
    check("gate_no_write", 32'(wr_q.size()), 32'(n0));
    check("gate_ready_low_cycles", 32'(low_cnt), 32'd0);
    check("gate_fifo_empty", 32'(fifo_empty), 32'd1);
    $display("gating: wr/rd strobes with cpu_win=0");

    // Table: single writes
    for (int i = 0; i < 6; i++) begin
      n0 = wr_q.size();
      c0 = cyc;
      cpu_write(vec[i].addr, vec[i].data);
      wait_writes(n0 + 1);
      if (wr_q.size() > n0) begin
        check("vec_ram_addr", 32'(wr_q[n0].addr), 32'(vec[i].exp_addr));
        check("vec_ram_be", 32'(wr_q[n0].be), 32'(vec[i].exp_be));
        check("vec_ram_wdata", wr_q[n0].wdata, vec[i].exp_wdata);
        check("vec_wr_within_3", 32'((wr_q[n0].cyc - c0) >= 1 && (wr_q[n0].cyc - c0) <= 3), 32'd1);
      end
      cycles(2);
      check("vec_single_we", 32'(wr_q.size()), 32'(n0 + 1));
      $display("write vec %0d: cpu_addr=%h data=%h ram_addr=%h be=%b", i, vec[i].addr,
               vec[i].data, vec[i].exp_addr, vec[i].exp_be);
    end

    // Table: read back each address
    for (int i = 0; i < 6; i++) begin
      cpu_read(vec[i].addr, d, lat);
      check("vec_cpu_din", 32'(d), 32'(vec[i].exp_din));
      check("vec_read_latency", 32'(lat), 32'd3);
      $display("read vec %0d: cpu_addr=%h din=%h ready_low=%0d", i, vec[i].addr, d, lat);
    end

    // Read-after-write: read strobe in the cycle right after the write strobe
    n0 = wr_q.size();
    cpu_addr = 16'hE0FF; cpu_dout = 8'h3C; cpu_win = 1'b1; cpu_wr = 1'b1;
    cycles(1);
    cpu_wr = 1'b0; cpu_win = 1'b0;
    cpu_read(16'hE0FF, d, lat);
    check("raw_din", 32'(d), 32'h3C);
    check("raw_ready_low_ge3", 32'(lat >= 3), 32'd1);
    check("raw_write_seen", 32'(wr_q.size()), 32'(n0 + 1));
    $display("raw: write 3c then read e0ff din=%h ready_low=%0d", d, lat);

    // Display priority: vid_req for 10 cycles with 3 writes queued meanwhile
    cycles(2);
    vid_q.delete();
    viol_cnt = 0;
    n0 = wr_q.size();
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          vid_req = 1'b1;
          vid_addr = 13'h1000 + 13'(k);
          @(posedge clk_sys); #1;
        end
        vid_req = 1'b0;
      end
      begin
        cpu_write(16'h8020, 8'h01);
        cpu_write(16'hA021, 8'h02);
        cpu_write(16'hC022, 8'h03);
      end
    join
    v_end = cyc;
    cycles(6);
    check("prio_no_we_during_vid", 32'(viol_cnt), 32'd0);
    check("prio_vid_valid_count", 32'(vid_q.size()), 32'd10);
    for (int k = 0; k < 10 && k < vid_q.size(); k++) begin
      check("prio_vid_data", vid_q[k], 32'hC0DE_0000 + 32'(k));
    end
    check("prio_write_count", 32'(wr_q.size() - n0), 32'd3);
    for (int j = 0; j < 3 && (n0 + j) < wr_q.size(); j++) begin
      check("prio_drain_cycle", 32'(wr_q[n0 + j].cyc - v_end), 32'(j));
    end
    if (wr_q.size() > n0) check("prio_first_addr", 32'(wr_q[n0].addr), 32'h0020);
    $display("priority: 10 fetches, %0d writes drained after vid_req fell", wr_q.size() - n0);

    // Overflow: 6 write events while vid_req blocks the port
    n0 = wr_q.size();
    vid_req = 1'b1; vid_addr = 13'h1000;
    for (int i = 0; i < 6; i++) begin
      cpu_write(16'h8000 + 16'(i), 8'h10 + 8'(i));
      @(negedge clk_sys);
      if (i == 4) begin
        check("ovf_ready_low_on_hold", 32'(cpu_ready), 32'd0);
        check("ovf_not_yet", 32'(overflow), 32'd0);
      end
      if (i == 5) check("ovf_set", 32'(overflow), 32'd1);
      @(posedge clk_sys); #1;
    end
    vid_req = 1'b0;
    cycles(12);
    check("ovf_write_count", 32'(wr_q.size() - n0), 32'd5);
    if (wr_q.size() >= n0 + 5) begin
      check("ovf_held_addr", 32'(wr_q[n0 + 4].addr), 32'h0004);
      check("ovf_held_wdata", wr_q[n0 + 4].wdata, 32'h14141414);
    end
    check("ovf_ready_back", 32'(cpu_ready), 32'd1);
    check("ovf_fifo_empty", 32'(fifo_empty), 32'd1);
    check("ovf_sticky", 32'(overflow), 32'd1);
    $display("overflow: 6 events, %0d writes reached RAM", wr_q.size() - n0);

    // Reset mid-operation: 3 queued writes and a pending read
    vid_req = 1'b1; vid_addr = 13'h1003;
    cpu_write(16'h8030, 8'hAA);
    cpu_write(16'h8031, 8'hBB);
    cpu_write(16'h8032, 8'hCC);
    cpu_addr = 16'h8030; cpu_win = 1'b1; cpu_rd = 1'b1;
    cycles(1);
    cpu_rd = 1'b0; cpu_win = 1'b0;
    @(negedge clk_sys);
    check("mid_read_pending", 32'(cpu_ready), 32'd0);
    check("mid_fifo_busy", 32'(fifo_empty), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_ram_we", 32'(ram_we), 32'd0);
    check("mid_rst_ram_be", 32'(ram_be), 32'd0);
    check("mid_rst_ram_addr", 32'(ram_addr), 32'd0);
    check("mid_rst_ram_wdata", ram_wdata, 32'd0);
    check("mid_rst_cpu_ready", 32'(cpu_ready), 32'd1);
    check("mid_rst_cpu_din", 32'(cpu_din), 32'd0);
    check("mid_rst_vid_data", vid_data, 32'd0);
    check("mid_rst_vid_valid", 32'(vid_valid), 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    check("mid_rst_fifo_empty", 32'(fifo_empty), 32'd1);
    vid_req = 1'b0;
    n0 = wr_q.size();
    @(posedge clk_sys); #1;
    cycles(2);
    reset_n = 1'b1;
    cycles(10);
    check("post_rst_no_we", 32'(wr_q.size()), 32'(n0));
    check("post_rst_fifo_empty", 32'(fifo_empty), 32'd1);
    check("post_rst_cpu_ready", 32'(cpu_ready), 32'd1);
    $display("reset mid-operation: queue flushed, read abandoned");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
